// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    CORE_PRI  = 1'b0,
    FORCE_DMA = 1'b1
  } arb_state_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // Widest address/data the request bundle carries; the arbiter narrows to its own parameters.
  localparam int unsigned DMA_ADDR_MAX_W = 32;
  localparam int unsigned DMA_DATA_MAX_W = 64;

  typedef struct packed {
    logic                      we;
    logic [DMA_ADDR_MAX_W-1:0] addr;
    logic [DMA_DATA_MAX_W-1:0] wdata;
  } dma_req_t;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters for the arbiter; only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_access,
  input  logic        dma_grant,
  input  logic        stall,
  output logic [31:0] stat_core_cnt,
  output logic [31:0] stat_dma_cnt,
  output logic [31:0] stat_stall_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_core_cnt  <= '0;
      stat_dma_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (core_access && (stat_core_cnt != '1))
        stat_core_cnt <= stat_core_cnt + 32'd1;
      if (dma_grant && (stat_dma_cnt != '1))
        stat_dma_cnt <= stat_dma_cnt + 32'd1;
      if (stall && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core MEM stage has priority, DMA gets a forced slot after STARVE_MAX lost cycles.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  dma_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_core_cnt,
  output logic [31:0]           stat_dma_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  dma_req_t   dma_in;
  logic       core_act;
  logic       dma_own;
  logic       core_own;

  always_comb begin
    dma_in       = '0;
    dma_in.we    = dma_we;
    dma_in.addr  = DMA_ADDR_MAX_W'(dma_addr);
    dma_in.wdata = DMA_DATA_MAX_W'(dma_wdata);
  end

  assign core_act = core_rd | core_wr;

  always_comb begin
    state_nxt  = CORE_PRI;
    starve_nxt = '0;
    dma_own    = 1'b0;
    dma_gnt    = 1'b0;
    core_stall = 1'b0;
    case (state)
      CORE_PRI: begin
        if (dma_req && !core_act) begin
          dma_own = 1'b1;
          dma_gnt = 1'b1;
        end else if (dma_req) begin
          starve_nxt = starve_cnt + 4'd1;
          if (starve_nxt == STARVE_LIM)
            state_nxt = FORCE_DMA;
        end
      end
      FORCE_DMA: begin
        core_stall = 1'b1;
        dma_own    = 1'b1;
        dma_gnt    = dma_req;
      end
      default: ;
    endcase
    // Reset silences every combinational output, including a grant that would otherwise be in flight.
    if (reset) begin
      dma_own    = 1'b0;
      dma_gnt    = 1'b0;
      core_stall = 1'b0;
    end
  end

  assign core_own = !reset && !dma_own;

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (dma_own) begin
      mem_rd     = dma_gnt & !dma_in.we;
      mem_wr     = dma_gnt & dma_in.we;
      mem_addr   = DM_ADDRESS'(dma_in.addr);
      mem_wdata  = DATA_W'(dma_in.wdata);
      mem_funct3 = FUNCT3_WORD;
    end else if (core_own) begin
      mem_rd     = core_rd;
      mem_wr     = core_wr;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
    end
  end

  assign core_rdata = core_own ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CORE_PRI;
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      dma_rvalid <= dma_gnt & !dma_in.we;
      if (dma_gnt && !dma_in.we)
        dma_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .core_access    (core_own & core_act),
    .dma_grant      (dma_gnt),
    .stall          (core_stall),
    .stat_core_cnt  (stat_core_cnt),
    .stat_dma_cnt   (stat_dma_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          core_rd, core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [2:0]    core_funct3;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   stat_core_cnt, stat_dma_cnt, stat_stall_cnt;
`endif

  dmem_arbiter #(
    .DM_ADDRESS (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_rd     (core_rd),
    .core_wr     (core_wr),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_funct3 (core_funct3),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_funct3  (mem_funct3),
    .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_cnt  (stat_core_cnt),
    .stat_dma_cnt   (stat_dma_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised memory: combinational read, write on the edge; poke port preloads words.
  logic [DW-1:0] tbmem [0:127];
  logic          poke;
  logic [6:0]    poke_addr;
  logic [DW-1:0] poke_data;

  assign mem_rdata = mem_rd ? tbmem[mem_addr[8:2]] : '0;

  always @(posedge clk) begin
    if (mem_wr)
      tbmem[mem_addr[8:2]] <= mem_wdata;
    else if (poke)
      tbmem[poke_addr] <= poke_data;
  end

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_rd     = 1'b0;
    core_wr     = 1'b0;
    core_addr   = '0;
    core_wdata  = '0;
    core_funct3 = 3'b010;
    dma_req     = 1'b0;
    dma_we      = 1'b0;
    dma_addr    = '0;
    dma_wdata   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [14:0] exp_bus;

  initial begin
    poke = 1'b0; poke_addr = '0; poke_data = '0;
    idle_inputs();
    reset = 1'b1;
    core_rd = 1'b1; core_addr = 9'h010; dma_req = 1'b1;
    tick(); tick();

    // Outputs held quiet while reset is high even with active requesters
    @(negedge clk);
    chk("rst_mem_rd",     {31'd0, mem_rd},     32'd0);
    chk("rst_stall",      {31'd0, core_stall}, 32'd0);
    chk("rst_gnt",        {31'd0, dma_gnt},    32'd0);
    chk("rst_mem_addr",   32'(mem_addr),       32'd0);
    chk("rst_funct3",     32'(mem_funct3),     32'd0);
    chk("rst_core_rdata", core_rdata,          32'd0);
    chk("rst_rvalid",     {31'd0, dma_rvalid}, 32'd0);
    chk("rst_rdata",      dma_rdata,           32'd0);
    tick();
    reset = 1'b0;
    idle_inputs();
    poke = 1'b1; poke_addr = 7'd4; poke_data = 32'h0000_1234;
    tick();
    poke = 1'b0;

    // Scenario 1: core idle, DMA write then read of 0x0C
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h00C; dma_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("s1_wr_gnt",    {31'd0, dma_gnt},    32'd1);
    chk("s1_wr_memwr",  {31'd0, mem_wr},     32'd1);
    chk("s1_wr_addr",   32'(mem_addr),       32'h00C);
    chk("s1_wr_funct3", 32'(mem_funct3),     32'd2);
    chk("s1_wr_stall",  {31'd0, core_stall}, 32'd0);
    tick();
    dma_we = 1'b0;
    @(negedge clk);
    chk("s1_rd_gnt",    {31'd0, dma_gnt},    32'd1);
    chk("s1_rd_memrd",  {31'd0, mem_rd},     32'd1);
    chk("s1_rd_stall",  {31'd0, core_stall}, 32'd0);
    chk("s1_rvalid_wr", {31'd0, dma_rvalid}, 32'd0);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    chk("s1_rvalid", {31'd0, dma_rvalid}, 32'd1);
    chk("s1_rdata",  dma_rdata,           32'hDEAD_BEEF);
    chk("s1_stall",  {31'd0, core_stall}, 32'd0);
    tick();
    @(negedge clk);
    chk("s1_rvalid_drop", {31'd0, dma_rvalid}, 32'd0);
    chk("s1_rdata_hold",  dma_rdata,           32'hDEAD_BEEF);
    tick();

    // Scenario 2: core loads 0x10 every cycle against a held DMA read of 0x0C
    core_rd = 1'b1; core_addr = 9'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h00C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s2_core_gnt",   {31'd0, dma_gnt},    32'd0);
      chk("s2_core_stall", {31'd0, core_stall}, 32'd0);
      chk("s2_core_addr",  32'(mem_addr),       32'h010);
      chk("s2_core_rdata", core_rdata,          32'h0000_1234);
      tick();
    end
    @(negedge clk);
    chk("s2_force_stall", {31'd0, core_stall}, 32'd1);
    chk("s2_force_gnt",   {31'd0, dma_gnt},    32'd1);
    chk("s2_force_addr",  32'(mem_addr),       32'h00C);
    chk("s2_force_memrd", {31'd0, mem_rd},     32'd1);
    chk("s2_force_f3",    32'(mem_funct3),     32'd2);
    chk("s2_force_crd",   core_rdata,          32'd0);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    chk("s2_resume_stall", {31'd0, core_stall}, 32'd0);
    chk("s2_resume_addr",  32'(mem_addr),       32'h010);
    chk("s2_resume_rdata", core_rdata,          32'h0000_1234);
    chk("s2_rvalid",       {31'd0, dma_rvalid}, 32'd1);
    chk("s2_dma_rdata",    dma_rdata,           32'hDEAD_BEEF);
    tick();

    // Scenario 3: core store 0x11 and DMA write 0x22 to 0x20 contend
    core_rd = 1'b0; core_wr = 1'b1; core_addr = 9'h020; core_wdata = 32'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h020; dma_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s3_core_wr",    {31'd0, mem_wr}, 32'd1);
      chk("s3_core_wdata", mem_wdata,       32'h11);
      chk("s3_core_gnt",   {31'd0, dma_gnt}, 32'd0);
      tick();
      if (i == 0) chk("s3_core_commit", tbmem[8], 32'h11);
    end
    @(negedge clk);
    chk("s3_force_stall", {31'd0, core_stall}, 32'd1);
    chk("s3_force_gnt",   {31'd0, dma_gnt},    32'd1);
    chk("s3_force_wdata", mem_wdata,           32'h22);
    tick();
    idle_inputs();
    chk("s3_final_mem", tbmem[8], 32'h22);

    // Scenario 4: core only for 20 cycles, mem_* mirrors core_*
    for (int i = 0; i < 20; i++) begin
      core_rd     = i[0];
      core_wr     = ~i[0];
      core_addr   = 9'(4 * i);
      core_wdata  = 32'(i * 32'h101);
      core_funct3 = 3'(i % 6);
      exp_bus     = {1'b0, i[0], ~i[0], 3'(i % 6), 9'(4 * i)};
      @(negedge clk);
      chk("s4_mirror", 32'({core_stall, mem_rd, mem_wr, mem_funct3, mem_addr}), 32'(exp_bus));
      chk("s4_wdata",  mem_wdata, 32'(i * 32'h101));
      tick();
    end
    // A counter left at zero means exactly four lost cycles before the forced slot
    core_rd = 1'b1; core_wr = 1'b0; core_addr = 9'h010; core_funct3 = 3'b010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h00C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s4_starve_stall", {31'd0, core_stall}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("s4_force_stall", {31'd0, core_stall}, 32'd1);
    tick();
    dma_req = 1'b0;
    tick();

    // Scenario 5: reset lands on the forced slot
    dma_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s5_pre_gnt", {31'd0, dma_gnt}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("s5_force_stall", {31'd0, core_stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("s5_rst_stall", {31'd0, core_stall}, 32'd0);
    chk("s5_rst_gnt",   {31'd0, dma_gnt},    32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s5_post_stall", {31'd0, core_stall}, 32'd0);
      if (i == 0) chk("s5_post_rvalid", {31'd0, dma_rvalid}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("s5_reforce_stall", {31'd0, core_stall}, 32'd1);
    chk("s5_reforce_gnt",   {31'd0, dma_gnt},    32'd1);
    tick();
    idle_inputs();

`ifdef DMEM_ARB_STATS_EN
    // Statistics: scenario 2 traffic for ten cycles after a clearing reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_rd = 1'b1; core_addr = 9'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h00C;
    for (int i = 0; i < 10; i++) tick();
    idle_inputs();
    @(negedge clk);
    chk("st_stall", stat_stall_cnt, 32'd2);
    chk("st_dma",   stat_dma_cnt,   32'd2);
    chk("st_core",  stat_core_cnt,  32'd8);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
